// File: rtl/cache_perf_pkg.sv
// cache_perf_pkg: FSM states, ASCII constants and nibble-to-hex helper for the perf reporter.
// PERF_RPT_CRLF_EN adds the CR/LF frame terminator states and their byte values.
package cache_perf_pkg;
`ifdef PERF_RPT_CRLF_EN
   typedef enum logic [2:0] {IDLE, TAG, DIGIT, CR, LF} state_t;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
`else
   typedef enum logic [1:0] {IDLE, TAG, DIGIT} state_t;
`endif
   localparam logic [7:0] TAG_BASE = 8'h61;
   function automatic logic [7:0] hex2ascii(input logic [3:0] v);
      return v < 4'd10 ? 8'h30 + {4'h0, v} : 8'h37 + {4'h0, v};
   endfunction
endpackage

// File: rtl/cache_perf_reporter_if.sv
// cache_perf_reporter_if: byte stream into the UART TX FIFO with almost-full backpressure.
interface cache_perf_reporter_if;
   logic [7:0] data_o;
   logic       wr_en;
   logic       fifo_full_i;
   modport master (output data_o, wr_en, input fifo_full_i);
   modport slave (input data_o, wr_en, output fifo_full_i);
endinterface

// File: rtl/cache_perf_reporter_event_counter.sv
// perf_event_counter: rising-edge detector feeding a wrapping event counter.
module perf_event_counter #(
   parameter int CNT_W = 12
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             ev,
   output logic [CNT_W-1:0] cnt
);
   logic prev;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         prev <= 1'b0;
         cnt  <= '0;
      end else begin
         prev <= ev;
         if (ev & ~prev) cnt <= cnt + CNT_W'(1);
      end
endmodule

// File: rtl/cache_perf_reporter.sv
// cache_perf_reporter: periodic snapshot of NUM_CH event counters streamed as ASCII hex to a FIFO.
// Define PERF_RPT_CRLF_EN to terminate each frame with CR LF.
module cache_perf_reporter
   import cache_perf_pkg::*;
#(
   parameter int NUM_CH = 8,
   parameter int CNT_W  = 12,
   parameter int PERIOD = 1000
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [NUM_CH-1:0]    event_i,
   cache_perf_reporter_if.master fifo,
   output logic                 busy_o,
   output logic                 overrun_o
);
   localparam int ND = CNT_W / 4;
   localparam int DW = ND > 1 ? $clog2(ND) : 1;
   localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int PW = PERIOD > 1 ? $clog2(PERIOD) : 1;
   logic [CNT_W-1:0] cnt  [NUM_CH];
   logic [CNT_W-1:0] snap [NUM_CH];
   logic [PW-1:0]    pcnt;
   logic [CW-1:0]    ch;
   logic [DW-1:0]    dig;
   logic [3:0]       nib;
   logic [7:0]       byte_nx;
   logic             tick, last_ch;
   state_t           state, state_nx;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
      perf_event_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk  (clk),
         .rstn (rstn),
         .ev   (event_i[k]),
         .cnt  (cnt[k])
      );
   end

   assign tick    = pcnt == PW'(PERIOD - 1);
   assign last_ch = ch == CW'(NUM_CH - 1);
   assign nib     = snap[ch][{dig, 2'b00} +: 4];

   // dig counts down so the most significant nibble goes out first
   always_comb begin
`ifdef PERF_RPT_CRLF_EN
      byte_nx  = state == TAG ? TAG_BASE + 8'(ch) : state == DIGIT ? hex2ascii(nib) :
                 state == CR ? ASCII_CR : ASCII_LF;
      state_nx = state == TAG ? DIGIT : state == DIGIT ? (dig != '0 ? DIGIT : last_ch ? CR : TAG) :
                 state == CR ? LF : IDLE;
`else
      byte_nx  = state == TAG ? TAG_BASE + 8'(ch) : hex2ascii(nib);
      state_nx = state == TAG ? DIGIT : dig != '0 ? DIGIT : last_ch ? IDLE : TAG;
`endif
   end

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         pcnt        <= '0;
         snap        <= '{default: '0};
         ch          <= '0;
         dig         <= '0;
         state       <= IDLE;
         fifo.data_o <= 8'h00;
         fifo.wr_en  <= 1'b0;
         busy_o      <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         pcnt <= tick ? '0 : pcnt + PW'(1);
         if (tick && state != IDLE) overrun_o <= 1'b1;
         if (state == IDLE) begin
            fifo.wr_en <= 1'b0;
            busy_o     <= tick;
            if (tick) begin
               snap  <= cnt;
               ch    <= '0;
               state <= TAG;
            end
         end else if (fifo.fifo_full_i) begin
            fifo.wr_en <= 1'b0;
         end else begin
            fifo.wr_en  <= 1'b1;
            fifo.data_o <= byte_nx;
            state       <= state_nx;
            dig         <= state == TAG ? DW'(ND - 1) : dig - DW'(1);
            if (state == DIGIT && dig == '0 && !last_ch) ch <= ch + CW'(1);
         end
      end
endmodule
